cache_arbiter: RTL and testbench
================================

# cache_arbiter

Arbitrates a single physical-memory port between the instruction cache and the data cache of the LC-3b core. Each cache presents its usual line-granular pmem interface (16-bit address, 128-bit line, read/write strobes, resp). The arbiter grants one requester at a time, latches its command, drives the shared memory, and returns the response to the granted cache. Fairness is round-robin, so neither cache can starve the other.

## Interface
- No parameters; widths come from `lc3b_word` (16 b) and `lc3b_cache_line` (128 b).
- `clk` in 1: system clock, all state on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `i_pmem_address` in 16: I-cache line address.
- `i_pmem_read` in 1: I-cache read request.
- `i_pmem_write` in 1: I-cache write request (tied 0 in practice; still arbitrated).
- `i_pmem_wdata` in 128: I-cache write line.
- `i_pmem_rdata` out 128: read line to I-cache.
- `i_pmem_resp` out 1: completion pulse to I-cache.
- `d_pmem_address`, `d_pmem_read`, `d_pmem_write`, `d_pmem_wdata`, `d_pmem_rdata`, `d_pmem_resp`: same set for the D-cache.
- `pmem_address` out 16: shared memory address.
- `pmem_read` out 1: shared memory read strobe.
- `pmem_write` out 1: shared memory write strobe.
- `pmem_wdata` out 128: shared memory write line.
- `pmem_rdata` in 128: shared memory read line.
- `pmem_resp` in 1: shared memory completion.

## Operation
- FSM states:
  - ARB_IDLE: no downstream strobes.
  - ARB_SERVE_I: I-cache owns memory.
  - ARB_SERVE_D: D-cache owns memory.
- A request is pending on a port when its read or write strobe is 1.
- ARB_IDLE, one port pending: grant that port. Go to ARB_SERVE_I or ARB_SERVE_D.
- ARB_IDLE, both ports pending: grant the port that was not granted last.
- Grant action:
  - Latch address and wdata from the granted port.
  - Latch op: write if that port's write is 1, else read. If read and write are both 1, write wins.
  - Update the `last_grant` register.
- ARB_SERVE_x: drive `pmem_address`/`pmem_wdata` from the latches. Drive `pmem_read` or `pmem_write` from the latched op. Hold them until `pmem_resp`.
- ARB_SERVE_x with `pmem_resp`=1 in the same cycle:
  - Assert `x_pmem_resp`; it is combinational and lasts one cycle.
  - Next state is ARB_IDLE.
  - The other port's resp stays 0.
- `i_pmem_rdata` and `d_pmem_rdata` are both wired straight from `pmem_rdata`. They are meaningful only with the matching resp.
- A requester whose strobes drop during ARB_SERVE is not aborted. The downstream transaction completes and resp is still pulsed.
- `pmem_resp` in ARB_IDLE is ignored.

## Timing
- Reset values:
  - state = ARB_IDLE.
  - `last_grant` = I, so the D-cache wins the first tie.
  - `pmem_read`, `pmem_write`, `i_pmem_resp`, `d_pmem_resp` = 0.
  - Address and wdata latches = 0.
- Grant latency: request seen in ARB_IDLE at cycle N; downstream strobe asserted at cycle N+1.
- Completion: `pmem_resp` at cycle M gives requester resp at cycle M, downstream strobes 0 at M+1, and ARB_IDLE at M+1.
- Back-to-back: the other pending port is granted in the ARB_IDLE cycle M+1 and gets its strobe at M+2. Downstream always sees at least one strobe-low cycle between transactions.
- The same port re-requesting at M+1 (e.g. dirty writeback then fill) is treated as a new request. It loses to the other port if both are pending.
- Reset asserted mid-transaction: at the next edge, return to ARB_IDLE with strobes 0. A late `pmem_resp` from the aborted transaction is ignored.
- No combinational path from requester inputs to `pmem_*` outputs.

## Structure
- Add to `lc3b_types`: `arb_state_t` enum {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} and `arb_port_t` enum {ARB_PORT_I, ARB_PORT_D}.
- Reuse the existing `lc3b_word` and `lc3b_cache_line` typedefs.
- Split in the same style as the cache:
  - FSM and `last_grant` in the top `cache_arbiter`.
  - Address/wdata/op latches and the grant-select mux in sub-module `cache_arbiter_datapath`.

## Test plan
- Reset, then I read at 0x1230 alone: `pmem_read`=1 and `pmem_address`=0x1230 from the next cycle. Memory resp after 3 cycles gives `i_pmem_resp`=1 for one cycle, with `i_pmem_rdata`=the memory line. `d_pmem_resp` stays 0.
- Both ports request in the same cycle after reset (I read 0x0040, D write 0x8000 with wdata 0xA5…A5): D is served first with `pmem_write`=1 and wdata 0xA5…A5. I read 0x0040 follows after exactly one idle cycle.
- Both ports request continuously for 6 transactions: grants alternate D,I,D,I,D,I. No port gets two consecutive grants while the other is pending.
- D writeback to 0x2000 then immediate fill read from 0x3000, with I idle: two downstream transactions in order, one idle cycle between, correct latched addresses.
- I changes `i_pmem_address` from 0x1000 to 0x5550 during ARB_SERVE_I: `pmem_address` stays 0x1000 until resp.
- `reset_n`=0 for one cycle mid-D-read, then a late `pmem_resp`: strobes drop at the reset edge, no resp is pulsed to either port, and a new I request is granted normally.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: datapath widths plus the cache arbiter's
// state and port encodings.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_cache_line;

   // Arbiter FSM states: idle, or serving one of the two caches.
   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_SERVE_I = 2'd1,
      ARB_SERVE_D = 2'd2
   } arb_state_t;

   // Identifies which cache a grant belongs to.
   typedef enum logic {
      ARB_PORT_I = 1'b0,
      ARB_PORT_D = 1'b1
   } arb_port_t;

   // Round-robin helper: the port that was not granted last.
   function automatic arb_port_t arb_other_port(input arb_port_t p);
      return (p == ARB_PORT_I) ? ARB_PORT_D : ARB_PORT_I;
   endfunction

endpackage

// File: rtl/cache_arbiter_datapath.sv
// Command latches for the cache arbiter. On a grant, the selected cache's
// address, write line and operation are captured and then held on the
// shared memory port for the whole transaction, so requester inputs never
// reach the pmem_* outputs combinationally.
module cache_arbiter_datapath
   import lc3b_types::*;
(
   input  logic           clk,
   input  logic           reset_n,
   input  logic           grant,
   input  arb_port_t      grant_port,
   input  lc3b_word       i_pmem_address,
   input  logic           i_pmem_write,
   input  lc3b_cache_line i_pmem_wdata,
   input  lc3b_word       d_pmem_address,
   input  logic           d_pmem_write,
   input  lc3b_cache_line d_pmem_wdata,
   output lc3b_word       pmem_address,
   output lc3b_cache_line pmem_wdata,
   output logic           op_write
);

   lc3b_word       sel_address;
   lc3b_cache_line sel_wdata;
   logic           sel_write;

   // Grant-select mux: pick the command of the port being granted.
   // A write strobe wins over a simultaneous read strobe.
   always_comb begin
      sel_address = i_pmem_address;
      sel_wdata   = i_pmem_wdata;
      sel_write   = i_pmem_write;
      if (grant_port == ARB_PORT_D) begin
         sel_address = d_pmem_address;
         sel_wdata   = d_pmem_wdata;
         sel_write   = d_pmem_write;
      end
   end

   // Capture the command only on a grant; hold it until the next grant.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pmem_address <= '0;
         pmem_wdata   <= '0;
         op_write     <= 1'b0;
      end else if (grant) begin
         pmem_address <= sel_address;
         pmem_wdata   <= sel_wdata;
         op_write     <= sel_write;
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache
// and D-cache.
//
// Handshake: a cache's request is pending while its read or write strobe is
// 1 (its "valid"); the arbiter answers with a one-cycle x_pmem_resp (its
// "ready/done") in the same cycle the memory raises pmem_resp. Downstream,
// pmem_read/pmem_write are held from the cycle after the grant until the
// cycle pmem_resp is seen, then drop for at least one idle cycle. A cache
// that drops its strobes mid-transaction is not aborted; it still gets resp.
module cache_arbiter
   import lc3b_types::*;
(
   input  logic           clk,
   input  logic           reset_n,
   input  lc3b_word       i_pmem_address,
   input  logic           i_pmem_read,
   input  logic           i_pmem_write,
   input  lc3b_cache_line i_pmem_wdata,
   output lc3b_cache_line i_pmem_rdata,
   output logic           i_pmem_resp,
   input  lc3b_word       d_pmem_address,
   input  logic           d_pmem_read,
   input  logic           d_pmem_write,
   input  lc3b_cache_line d_pmem_wdata,
   output lc3b_cache_line d_pmem_rdata,
   output logic           d_pmem_resp,
   output lc3b_word       pmem_address,
   output logic           pmem_read,
   output logic           pmem_write,
   output lc3b_cache_line pmem_wdata,
   input  lc3b_cache_line pmem_rdata,
   input  logic           pmem_resp,
   output arb_state_t     dbg_state
);

   arb_state_t state, next_state;
   arb_port_t  last_grant, next_last_grant;
   arb_port_t  grant_port;
   logic       grant;
   logic       i_pending, d_pending;
   logic       op_write;

   assign i_pending = i_pmem_read | i_pmem_write;
   assign d_pending = d_pmem_read | d_pmem_write;

   // State and round-robin history registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ARB_IDLE;
         last_grant <= ARB_PORT_I;
      end else begin
         state      <= next_state;
         last_grant <= next_last_grant;
      end
   end

   // Next-state, grant decision and completion pulses.
   always_comb begin
      next_state      = state;
      next_last_grant = last_grant;
      grant           = 1'b0;
      grant_port      = ARB_PORT_I;
      i_pmem_resp     = 1'b0;
      d_pmem_resp     = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (i_pending && d_pending) begin
               grant      = 1'b1;
               grant_port = arb_other_port(last_grant);
            end else if (d_pending) begin
               grant      = 1'b1;
               grant_port = ARB_PORT_D;
            end else if (i_pending) begin
               grant      = 1'b1;
               grant_port = ARB_PORT_I;
            end
            if (grant) begin
               next_last_grant = grant_port;
               next_state      = (grant_port == ARB_PORT_D) ? ARB_SERVE_D : ARB_SERVE_I;
            end
         end
         ARB_SERVE_I: begin
            if (pmem_resp) begin
               i_pmem_resp = 1'b1;
               next_state  = ARB_IDLE;
            end
         end
         ARB_SERVE_D: begin
            if (pmem_resp) begin
               d_pmem_resp = 1'b1;
               next_state  = ARB_IDLE;
            end
         end
         default: next_state = ARB_IDLE;
      endcase
   end

   cache_arbiter_datapath u_datapath (
      .clk            (clk),
      .reset_n        (reset_n),
      .grant          (grant),
      .grant_port     (grant_port),
      .i_pmem_address (i_pmem_address),
      .i_pmem_write   (i_pmem_write),
      .i_pmem_wdata   (i_pmem_wdata),
      .d_pmem_address (d_pmem_address),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_wdata   (d_pmem_wdata),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .op_write       (op_write)
   );

   // Strobes come only from registered state and latched op.
   assign pmem_read    = (state != ARB_IDLE) && !op_write;
   assign pmem_write   = (state != ARB_IDLE) &&  op_write;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;
   assign dbg_state    = state;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed testbench for cache_arbiter: each task drives one scenario at
// the falling edge and checks outputs #1 later, away from the rising edge.
module tb_cache_arbiter;
   import lc3b_types::*;

   logic           clk;
   logic           reset_n;
   lc3b_word       i_pmem_address;
   logic           i_pmem_read;
   logic           i_pmem_write;
   lc3b_cache_line i_pmem_wdata;
   lc3b_cache_line i_pmem_rdata;
   logic           i_pmem_resp;
   lc3b_word       d_pmem_address;
   logic           d_pmem_read;
   logic           d_pmem_write;
   lc3b_cache_line d_pmem_wdata;
   lc3b_cache_line d_pmem_rdata;
   logic           d_pmem_resp;
   lc3b_word       pmem_address;
   logic           pmem_read;
   logic           pmem_write;
   lc3b_cache_line pmem_wdata;
   lc3b_cache_line pmem_rdata;
   logic           pmem_resp;
   arb_state_t     dbg_state;

   int total = 0;
   int bad   = 0;

   cache_arbiter dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_pmem_address (i_pmem_address),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_write   (i_pmem_write),
      .i_pmem_wdata   (i_pmem_wdata),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_address (d_pmem_address),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .pmem_address   (pmem_address),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp),
      .dbg_state      (dbg_state)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      i_pmem_address = '0; i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_pmem_wdata = '0;
      d_pmem_address = '0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
      pmem_rdata = '0; pmem_resp = 1'b0;
   endtask

   // Leaves the caller at a falling edge with reset released and state idle.
   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      i_pmem_read = 1'b1;
      pmem_resp = 1'b1;
      @(negedge clk);
      #1;
      total++; if (dbg_state !== ARB_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ARB_IDLE); end
      total++; if ({pmem_read, pmem_write} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {pmem_read, pmem_write}); end
      total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin bad++; $display("FAIL reset_resp: got %b want 00", {i_pmem_resp, d_pmem_resp}); end
      total++; if (pmem_address !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h want 0000", pmem_address); end
      total++; if (pmem_wdata !== 128'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", pmem_wdata); end
      i_pmem_read = 1'b0;
      reset_n = 1'b1;
      // pmem_resp still high while idle: must be ignored
      @(negedge clk);
      #1;
      total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin bad++; $display("FAIL idle_resp_ignored: got %b want 00", {i_pmem_resp, d_pmem_resp}); end
      total++; if (dbg_state !== ARB_IDLE) begin bad++; $display("FAIL idle_stays: got %0d want %0d", dbg_state, ARB_IDLE); end
      pmem_resp = 1'b0;
   endtask

   task automatic test_single_read();
      lc3b_cache_line line;
      line = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
      apply_reset();
      i_pmem_address = 16'h1230;
      i_pmem_read = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         total++; if ({pmem_read, pmem_write} !== 2'b10) begin bad++; $display("FAIL single_strobe c%0d: got %b want 10", c, {pmem_read, pmem_write}); end
         total++; if (pmem_address !== 16'h1230) begin bad++; $display("FAIL single_addr c%0d: got %h want 1230", c, pmem_address); end
         total++; if (i_pmem_resp !== 1'b0) begin bad++; $display("FAIL single_early_resp c%0d: got %b want 0", c, i_pmem_resp); end
      end
      @(negedge clk);
      pmem_resp = 1'b1;
      pmem_rdata = line;
      #1;
      total++; if (i_pmem_resp !== 1'b1) begin bad++; $display("FAIL single_i_resp: got %b want 1", i_pmem_resp); end
      total++; if (d_pmem_resp !== 1'b0) begin bad++; $display("FAIL single_d_resp: got %b want 0", d_pmem_resp); end
      total++; if (i_pmem_rdata !== line) begin bad++; $display("FAIL single_rdata: got %h want %h", i_pmem_rdata, line); end
      i_pmem_read = 1'b0;
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      total++; if ({pmem_read, pmem_write} !== 2'b00) begin bad++; $display("FAIL single_after_strobes: got %b want 00", {pmem_read, pmem_write}); end
      total++; if (i_pmem_resp !== 1'b0) begin bad++; $display("FAIL single_resp_one_cycle: got %b want 0", i_pmem_resp); end
      total++; if (dbg_state !== ARB_IDLE) begin bad++; $display("FAIL single_idle: got %0d want %0d", dbg_state, ARB_IDLE); end
   endtask

   task automatic test_tie();
      lc3b_cache_line a5;
      a5 = {16{8'hA5}};
      apply_reset();
      i_pmem_address = 16'h0040; i_pmem_read = 1'b1;
      d_pmem_address = 16'h8000; d_pmem_write = 1'b1; d_pmem_wdata = a5;
      @(negedge clk);
      #1;
      total++; if (dbg_state !== ARB_SERVE_D) begin bad++; $display("FAIL tie_first_d: got %0d want %0d", dbg_state, ARB_SERVE_D); end
      total++; if ({pmem_read, pmem_write} !== 2'b01) begin bad++; $display("FAIL tie_d_write: got %b want 01", {pmem_read, pmem_write}); end
      total++; if (pmem_address !== 16'h8000) begin bad++; $display("FAIL tie_d_addr: got %h want 8000", pmem_address); end
      total++; if (pmem_wdata !== a5) begin bad++; $display("FAIL tie_d_wdata: got %h want %h", pmem_wdata, a5); end
      pmem_resp = 1'b1;
      #1;
      total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin bad++; $display("FAIL tie_d_resp: got %b want 01", {i_pmem_resp, d_pmem_resp}); end
      d_pmem_write = 1'b0;
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      total++; if ({pmem_read, pmem_write} !== 2'b00) begin bad++; $display("FAIL tie_gap: got %b want 00", {pmem_read, pmem_write}); end
      @(negedge clk);
      #1;
      total++; if (dbg_state !== ARB_SERVE_I) begin bad++; $display("FAIL tie_then_i: got %0d want %0d", dbg_state, ARB_SERVE_I); end
      total++; if ({pmem_read, pmem_write} !== 2'b10) begin bad++; $display("FAIL tie_i_read: got %b want 10", {pmem_read, pmem_write}); end
      total++; if (pmem_address !== 16'h0040) begin bad++; $display("FAIL tie_i_addr: got %h want 0040", pmem_address); end
      pmem_resp = 1'b1;
      #1;
      total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin bad++; $display("FAIL tie_i_resp: got %b want 10", {i_pmem_resp, d_pmem_resp}); end
      i_pmem_read = 1'b0;
      @(negedge clk);
      pmem_resp = 1'b0;
   endtask

   task automatic test_round_robin();
      arb_state_t exp_state;
      lc3b_word   exp_addr;
      apply_reset();
      i_pmem_address = 16'h1000; i_pmem_read = 1'b1;
      d_pmem_address = 16'h9000; d_pmem_read = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_state = (k % 2 == 0) ? ARB_SERVE_D : ARB_SERVE_I;
         exp_addr  = (k % 2 == 0) ? 16'h9000 : 16'h1000;
         @(negedge clk);
         #1;
         total++; if (dbg_state !== exp_state) begin bad++; $display("FAIL rr_grant k%0d: got %0d want %0d", k, dbg_state, exp_state); end
         total++; if (pmem_address !== exp_addr) begin bad++; $display("FAIL rr_addr k%0d: got %h want %h", k, pmem_address, exp_addr); end
         pmem_resp = 1'b1;
         #1;
         total++; if ({i_pmem_resp, d_pmem_resp} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
            bad++; $display("FAIL rr_resp k%0d: got %b want %b", k, {i_pmem_resp, d_pmem_resp}, (k % 2 == 0) ? 2'b01 : 2'b10);
         end
         @(negedge clk);
         pmem_resp = 1'b0;
         #1;
         total++; if ({pmem_read, pmem_write} !== 2'b00) begin bad++; $display("FAIL rr_gap k%0d: got %b want 00", k, {pmem_read, pmem_write}); end
         if (k == 5) begin
            i_pmem_read = 1'b0;
            d_pmem_read = 1'b0;
         end
      end
   endtask

   task automatic test_writeback_fill();
      lc3b_cache_line wb;
      wb = {8{16'h5A3C}};
      apply_reset();
      d_pmem_address = 16'h2000; d_pmem_write = 1'b1; d_pmem_wdata = wb;
      @(negedge clk);
      #1;
      total++; if ({pmem_read, pmem_write} !== 2'b01) begin bad++; $display("FAIL wb_strobe: got %b want 01", {pmem_read, pmem_write}); end
      total++; if (pmem_address !== 16'h2000) begin bad++; $display("FAIL wb_addr: got %h want 2000", pmem_address); end
      total++; if (pmem_wdata !== wb) begin bad++; $display("FAIL wb_wdata: got %h want %h", pmem_wdata, wb); end
      pmem_resp = 1'b1;
      #1;
      total++; if (d_pmem_resp !== 1'b1) begin bad++; $display("FAIL wb_resp: got %b want 1", d_pmem_resp); end
      d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 16'h3000;
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      total++; if ({pmem_read, pmem_write} !== 2'b00) begin bad++; $display("FAIL wb_gap: got %b want 00", {pmem_read, pmem_write}); end
      @(negedge clk);
      #1;
      total++; if ({pmem_read, pmem_write} !== 2'b10) begin bad++; $display("FAIL fill_strobe: got %b want 10", {pmem_read, pmem_write}); end
      total++; if (pmem_address !== 16'h3000) begin bad++; $display("FAIL fill_addr: got %h want 3000", pmem_address); end
      pmem_resp = 1'b1;
      #1;
      total++; if (d_pmem_resp !== 1'b1) begin bad++; $display("FAIL fill_resp: got %b want 1", d_pmem_resp); end
      d_pmem_read = 1'b0;
      @(negedge clk);
      pmem_resp = 1'b0;
   endtask

   task automatic test_write_wins();
      apply_reset();
      d_pmem_address = 16'h2222; d_pmem_read = 1'b1; d_pmem_write = 1'b1;
      @(negedge clk);
      #1;
      total++; if ({pmem_read, pmem_write} !== 2'b01) begin bad++; $display("FAIL write_wins: got %b want 01", {pmem_read, pmem_write}); end
      pmem_resp = 1'b1;
      d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      @(negedge clk);
      pmem_resp = 1'b0;
   endtask

   task automatic test_addr_hold();
      apply_reset();
      i_pmem_address = 16'h1000; i_pmem_read = 1'b1;
      @(negedge clk);
      i_pmem_address = 16'h5550;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         total++; if (pmem_address !== 16'h1000) begin bad++; $display("FAIL hold_addr c%0d: got %h want 1000", c, pmem_address); end
         if (c == 1) i_pmem_read = 1'b0;   // requester gives up; must not abort
      end
      total++; if ({pmem_read, pmem_write} !== 2'b10) begin bad++; $display("FAIL hold_strobe: got %b want 10", {pmem_read, pmem_write}); end
      pmem_resp = 1'b1;
      #1;
      total++; if (i_pmem_resp !== 1'b1) begin bad++; $display("FAIL hold_resp: got %b want 1", i_pmem_resp); end
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      total++; if (dbg_state !== ARB_IDLE) begin bad++; $display("FAIL hold_idle: got %0d want %0d", dbg_state, ARB_IDLE); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      d_pmem_address = 16'h4444; d_pmem_read = 1'b1;
      @(negedge clk);
      #1;
      total++; if (dbg_state !== ARB_SERVE_D) begin bad++; $display("FAIL mid_serving: got %0d want %0d", dbg_state, ARB_SERVE_D); end
      reset_n = 1'b0;
      @(negedge clk);
      #1;
      total++; if ({pmem_read, pmem_write} !== 2'b00) begin bad++; $display("FAIL mid_strobes: got %b want 00", {pmem_read, pmem_write}); end
      total++; if (dbg_state !== ARB_IDLE) begin bad++; $display("FAIL mid_idle: got %0d want %0d", dbg_state, ARB_IDLE); end
      reset_n = 1'b1;
      d_pmem_read = 1'b0;
      pmem_resp = 1'b1;   // late response from the aborted read
      #1;
      total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin bad++; $display("FAIL mid_late_resp: got %b want 00", {i_pmem_resp, d_pmem_resp}); end
      @(negedge clk);
      pmem_resp = 1'b0;
      i_pmem_address = 16'h7770; i_pmem_read = 1'b1;
      #1;
      total++; if ({pmem_read, pmem_write} !== 2'b00) begin bad++; $display("FAIL mid_no_regrant: got %b want 00", {pmem_read, pmem_write}); end
      @(negedge clk);
      #1;
      total++; if (dbg_state !== ARB_SERVE_I) begin bad++; $display("FAIL mid_new_i: got %0d want %0d", dbg_state, ARB_SERVE_I); end
      total++; if (pmem_address !== 16'h7770) begin bad++; $display("FAIL mid_new_addr: got %h want 7770", pmem_address); end
      pmem_resp = 1'b1;
      #1;
      total++; if (i_pmem_resp !== 1'b1) begin bad++; $display("FAIL mid_new_resp: got %b want 1", i_pmem_resp); end
      i_pmem_read = 1'b0;
      @(negedge clk);
      pmem_resp = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      test_reset();
      test_single_read();
      test_tie();
      test_round_robin();
      test_writeback_fill();
      test_write_wins();
      test_addr_hold();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
